// File: rtl/ahb_pkg.sv
// Shared AHB encodings and the AHB-to-APB bridge state type.
package ahb_pkg;

  typedef enum logic [1:0] {
    HtransIdle   = 2'b00,
    HtransBusy   = 2'b01,
    HtransNonseq = 2'b10,
    HtransSeq    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    HrespOkay  = 2'b00,
    HrespError = 2'b01,
    HrespRetry = 2'b10,
    HrespSplit = 2'b11
  } hresp_e;

  typedef enum logic [2:0] {
    StIdle,
    StWlatch,
    StSetup,
    StAccess,
    StDone,
    StErr1,
    StErr2
  } bridge_state_e;

endpackage

// File: rtl/ahb_apb_bridge.sv
// Single-transfer AHB slave to APB3 master bridge with wait-state insertion.
// Optional APB_PSLVERR_EN adds the PSLVERR port and a two-cycle AHB ERROR response.
module ahb_apb_bridge
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic [31:0]       HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [31:0]       HWDATA,
  input  logic              HREADY,
  output logic              HREADYOUT,
  output logic [1:0]        HRESP,
  output logic [31:0]       HRDATA,
  output logic [ADDR_W-1:0] PADDR,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [31:0]       PWDATA,
  input  logic [31:0]       PRDATA,
`ifdef APB_PSLVERR_EN
  input  logic              PSLVERR,
`endif
  input  logic              PREADY
);

  bridge_state_e     state_q, state_d;
  logic [ADDR_W-1:0] paddr_q;
  logic              pwrite_q;
  logic [31:0]       pwdata_q;
  logic [31:0]       hrdata_q;

  logic accept;
  logic can_accept;
  logic apb_err;
  logic capture_rdata;

  // HSIZE and the address bits outside the APB window are intentionally unused.
  logic unused_bits;
  assign unused_bits = ^{HSIZE, HADDR[31:ADDR_W], HADDR[1:0]};

  assign accept = HSEL && HREADY &&
                  ((HTRANS == HtransNonseq) || (HTRANS == HtransSeq));

`ifdef APB_PSLVERR_EN
  assign apb_err = PSLVERR;
`else
  assign apb_err = 1'b0;
`endif

  assign can_accept    = (state_q == StIdle) || (state_q == StDone) || (state_q == StErr2);
  assign capture_rdata = (state_q == StAccess) && PREADY && !pwrite_q && !apb_err;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = HWRITE ? StWlatch : StSetup;
      end
      StWlatch: state_d = StSetup;
      StSetup:  state_d = StAccess;
      StAccess: begin
        if (PREADY) state_d = apb_err ? StErr1 : StDone;
      end
      StDone: begin
        if (accept) state_d = HWRITE ? StWlatch : StSetup;
        else        state_d = StIdle;
      end
`ifdef APB_PSLVERR_EN
      StErr1: state_d = StErr2;
      StErr2: begin
        if (accept) state_d = HWRITE ? StWlatch : StSetup;
        else        state_d = StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= StIdle;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      hrdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (can_accept && accept) begin
        paddr_q  <= {HADDR[ADDR_W-1:2], 2'b00};
        pwrite_q <= HWRITE;
      end
      // Write data arrives in the AHB data phase, one cycle after the address.
      if (state_q == StWlatch) pwdata_q <= HWDATA;
      if (capture_rdata)       hrdata_q <= PRDATA;
    end
  end

  always_comb begin
    HREADYOUT = 1'b0;
    HRESP     = HrespOkay;
    PSEL      = 1'b0;
    PENABLE   = 1'b0;
    unique case (state_q)
      StIdle, StDone: HREADYOUT = 1'b1;
      StSetup:        PSEL = 1'b1;
      StAccess: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
      end
`ifdef APB_PSLVERR_EN
      StErr1: HRESP = HrespError;
      StErr2: begin
        HREADYOUT = 1'b1;
        HRESP     = HrespError;
      end
`endif
      default: HREADYOUT = 1'b0;
    endcase
  end

  assign PADDR  = paddr_q;
  assign PWRITE = pwrite_q;
  assign PWDATA = pwdata_q;
  assign HRDATA = hrdata_q;

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Directed self-checking bench for ahb_apb_bridge; error-path test needs APB_PSLVERR_EN.
module tb_ahb_apb_bridge;

  logic        HCLK;
  logic        HRESETn;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [1:0]  HRESP;
  logic [31:0] HRDATA;
  logic [15:0] PADDR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
`ifdef APB_PSLVERR_EN
  logic        PSLVERR;
`endif

  int n_checks;
  int n_fails;

  ahb_apb_bridge #(.ADDR_W(16)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HWDATA    (HWDATA),
    .HREADY    (HREADY),
    .HREADYOUT (HREADYOUT),
    .HRESP     (HRESP),
    .HRDATA    (HRDATA),
    .PADDR     (PADDR),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
`ifdef APB_PSLVERR_EN
    .PSLVERR   (PSLVERR),
`endif
    .PREADY    (PREADY)
  );

  // Single-slave bus: the bridge's own ready drives the bus ready.
  assign HREADY = HREADYOUT;

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic bus_idle();
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    bus_idle();
    HADDR  = '0;
    HSIZE  = 3'b010;
    HWDATA = '0;
    PRDATA = '0;
    PREADY = 1'b1;
`ifdef APB_PSLVERR_EN
    PSLVERR = 1'b0;
`endif
    #12;
    n_checks++;
    if ({HREADYOUT, HRESP, PSEL, PENABLE, PWRITE} !== 6'b100000) begin
      $display("FAIL reset_ctrl: got %b required 100000",
               {HREADYOUT, HRESP, PSEL, PENABLE, PWRITE});
      n_fails++;
    end
    n_checks++;
    if (HRDATA !== 32'h0 || PADDR !== 16'h0 || PWDATA !== 32'h0) begin
      $display("FAIL reset_data: HRDATA=%h PADDR=%h PWDATA=%h required all zero",
               HRDATA, PADDR, PWDATA);
      n_fails++;
    end
    HRESETn = 1'b1;
    tick();
  endtask

  task automatic test_read();
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h0000_0010;
    PREADY = 1'b1; PRDATA = 32'hCAFE_F00D;
    tick();                                      // edge N accepts address
    bus_idle();
    n_checks++;
    if ({PSEL, PENABLE, PWRITE, HREADYOUT} !== 4'b1000 || PADDR !== 16'h0010) begin
      $display("FAIL read_setup: psel/pen/pwr/hrdy=%b PADDR=%h required 1000 0010",
               {PSEL, PENABLE, PWRITE, HREADYOUT}, PADDR);
      n_fails++;
    end
    tick();
    n_checks++;
    if ({PSEL, PENABLE, HREADYOUT} !== 3'b110) begin
      $display("FAIL read_access: psel/pen/hrdy=%b required 110", {PSEL, PENABLE, HREADYOUT});
      n_fails++;
    end
    tick();
    n_checks++;
    if (HREADYOUT !== 1'b1 || HRESP !== 2'b00 || PSEL !== 1'b0) begin
      $display("FAIL read_done: hrdy=%b HRESP=%b PSEL=%b required 1 00 0", HREADYOUT, HRESP, PSEL);
      n_fails++;
    end
    n_checks++;
    if (HRDATA !== 32'hCAFE_F00D) begin
      $display("FAIL read_data: got %h required cafef00d", HRDATA);
      n_fails++;
    end
  endtask

  task automatic test_write_wait();
    int waits;
    int acc;
    bit done;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h0000_0024;
    PREADY = 1'b0;
    tick();
    bus_idle();
    HWDATA = 32'h1234_5678;
    waits = 0; acc = 0; done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (HREADYOUT) begin
        done = 1'b1;
        break;
      end
      waits++;
      if (i == 1) HWDATA = 32'hDEAD_BEEF;       // must already have been captured
      if (PSEL && PENABLE) begin
        acc++;
        n_checks++;
        if (PWDATA !== 32'h1234_5678 || PADDR !== 16'h0024 || PWRITE !== 1'b1) begin
          $display("FAIL write_stable: PWDATA=%h PADDR=%h PWRITE=%b required 12345678 0024 1",
                   PWDATA, PADDR, PWRITE);
          n_fails++;
        end
      end
      PREADY = (acc >= 4);
      tick();
    end
    PREADY = 1'b1;
    n_checks++;
    if (!done) begin
      $display("FAIL write_timeout: HREADYOUT never returned high");
      n_fails++;
    end
    n_checks++;
    if (waits != 6) begin
      $display("FAIL write_waits: got %0d required 6", waits);
      n_fails++;
    end
    n_checks++;
    if (HRDATA !== 32'hCAFE_F00D) begin
      $display("FAIL write_hrdata: got %h required cafef00d", HRDATA);
      n_fails++;
    end
  endtask

  task automatic test_back_to_back();
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h0000_0004;
    PREADY = 1'b1;
    tick();                                      // WLATCH
    bus_idle();
    HWDATA = 32'hA5A5_0004;
    tick();                                      // SETUP
    n_checks++;
    if (PSEL !== 1'b1 || PWRITE !== 1'b1 || PADDR !== 16'h0004 || PWDATA !== 32'hA5A5_0004) begin
      $display("FAIL b2b_wsetup: PSEL=%b PWRITE=%b PADDR=%h PWDATA=%h required 1 1 0004 a5a50004",
               PSEL, PWRITE, PADDR, PWDATA);
      n_fails++;
    end
    tick();                                      // ACCESS
    tick();                                      // DONE
    n_checks++;
    if (HREADYOUT !== 1'b1 || PSEL !== 1'b0) begin
      $display("FAIL b2b_wdone: hrdy=%b PSEL=%b required 1 0", HREADYOUT, PSEL);
      n_fails++;
    end
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h0000_0008;
    PRDATA = 32'h1111_2222;
    tick();                                      // must be SETUP directly
    bus_idle();
    n_checks++;
    if ({PSEL, PENABLE, PWRITE} !== 3'b100 || PADDR !== 16'h0008) begin
      $display("FAIL b2b_rsetup: psel/pen/pwr=%b PADDR=%h required 100 0008",
               {PSEL, PENABLE, PWRITE}, PADDR);
      n_fails++;
    end
    tick();
    tick();
    n_checks++;
    if (HREADYOUT !== 1'b1 || HRDATA !== 32'h1111_2222) begin
      $display("FAIL b2b_rdata: hrdy=%b HRDATA=%h required 1 11112222", HREADYOUT, HRDATA);
      n_fails++;
    end
    tick();                                      // back to IDLE
  endtask

  task automatic test_ignored();
    int bad;
    bad = 0;
    HSEL = 1'b1; HTRANS = 2'b01; HWRITE = 1'b0; HADDR = 32'h0000_0040;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (PSEL !== 1'b0 || HREADYOUT !== 1'b1) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      $display("FAIL ignore_busy: %0d bad cycles required 0", bad);
      n_fails++;
    end
    bad = 0;
    HSEL = 1'b0; HTRANS = 2'b10; HWRITE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (PSEL !== 1'b0 || HREADYOUT !== 1'b1 || HRESP !== 2'b00) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      $display("FAIL ignore_unsel: %0d bad cycles required 0", bad);
      n_fails++;
    end
    bus_idle();
    tick();
  endtask

`ifdef APB_PSLVERR_EN
  task automatic test_error();
    logic [31:0] prev;
    prev = HRDATA;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h0000_000C;
    PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 32'h5555_AAAA;
    tick();
    bus_idle();
    tick();                                      // ACCESS
    tick();                                      // ERR1
    PSLVERR = 1'b0;
    n_checks++;
    if (HRESP !== 2'b01 || HREADYOUT !== 1'b0) begin
      $display("FAIL err1: HRESP=%b hrdy=%b required 01 0", HRESP, HREADYOUT);
      n_fails++;
    end
    tick();                                      // ERR2
    n_checks++;
    if (HRESP !== 2'b01 || HREADYOUT !== 1'b1 || HRDATA !== prev) begin
      $display("FAIL err2: HRESP=%b hrdy=%b HRDATA=%h required 01 1 %h",
               HRESP, HREADYOUT, HRDATA, prev);
      n_fails++;
    end
    tick();
    n_checks++;
    if (HRESP !== 2'b00 || HREADYOUT !== 1'b1) begin
      $display("FAIL err_idle: HRESP=%b hrdy=%b required 00 1", HRESP, HREADYOUT);
      n_fails++;
    end
  endtask
`endif

  task automatic test_reset_midflight();
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h0000_0030;
    PREADY = 1'b0;
    tick();
    bus_idle();
    tick();                                      // ACCESS, stalled
    n_checks++;
    if ({PSEL, PENABLE, HREADYOUT} !== 3'b110 || HRDATA === 32'h0) begin
      $display("FAIL rst_pre: psel/pen/hrdy=%b HRDATA=%h required 110 nonzero",
               {PSEL, PENABLE, HREADYOUT}, HRDATA);
      n_fails++;
    end
    #1 HRESETn = 1'b0;
    #1;
    n_checks++;
    if ({PSEL, PENABLE, HREADYOUT} !== 3'b001 || HRDATA !== 32'h0 || PADDR !== 16'h0) begin
      $display("FAIL rst_async: psel/pen/hrdy=%b HRDATA=%h PADDR=%h required 001 0 0",
               {PSEL, PENABLE, HREADYOUT}, HRDATA, PADDR);
      n_fails++;
    end
    #1 HRESETn = 1'b1;
    PREADY = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({PSEL, PENABLE, HREADYOUT} !== 3'b001) begin
      $display("FAIL rst_idle: psel/pen/hrdy=%b required 001", {PSEL, PENABLE, HREADYOUT});
      n_fails++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    test_reset();
    test_read();
    test_write_wait();
    test_back_to_back();
    test_ignored();
`ifdef APB_PSLVERR_EN
    test_error();
`endif
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
